// File: rtl/booth_display_pkg.sv
// Shared types and sizes for the Booth product display path.
// BCD_WIDTH is also used by the display driver so the two sides of
// codigo_BCD always agree on width.
package booth_display_pkg;

  localparam int PRODUCT_WIDTH = 16;
  localparam int BCD_DIGITS    = 5;
  localparam int BCD_WIDTH     = 4 * BCD_DIGITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/binary_to_bcd_converter_if.sv
// Request/result bundle between the Booth multiplier side and the
// binary-to-BCD converter. The master drives a conversion request; the
// slave reports busy/done and the registered BCD word.
interface binary_to_bcd_converter_if
  import booth_display_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
);

  logic                start;
  logic [WIDTH-1:0]    binary_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS:0]   codigo_BCD;

  modport master (
    output start,
    output binary_in,
    input  busy,
    input  done,
    input  codigo_BCD
  );

  modport slave (
    input  start,
    input  binary_in,
    output busy,
    output done,
    output codigo_BCD
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add 3 only when the shifted digit would otherwise exceed 9.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter: signed two's-complement product in,
// sign plus DIGITS BCD digits out. One magnitude bit is consumed per cycle;
// the published word only changes on the cycle that raises done, so the
// display stays stable while a new conversion runs.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result register holds the last value
// SHIFT | one add-3 + shift per cycle, WIDTH cycles in total
// DONE  | publish {sign, scratch}; done pulses in the following cycle
//
// DIGITS must satisfy 10^DIGITS > 2^(WIDTH-1) so the most negative input
// (whose magnitude still fits in WIDTH unsigned bits) is representable.
module binary_to_bcd_converter
  import booth_display_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                       clk,
  input  logic                       reset,
  binary_to_bcd_converter_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_sign;
  logic [WIDTH-1:0]  r_mag;
  logic [SW-1:0]     r_scratch;
  logic [SW-1:0]     w_adj;
  logic [CW-1:0]     r_cnt;
  logic [SW:0]       r_bcd;
  logic              r_done;
  logic              w_last_shift;

  // Per-digit add-3 correction on the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_last_shift = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start is only looked at in IDLE, so nothing queues.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = SHIFT;
      SHIFT:   if (w_last_shift) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture sign/magnitude, shift through the digits, publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // The most negative input negates to itself, which read as
            // unsigned is exactly its magnitude, so no extra bit is needed.
            r_sign    <= bus.binary_in[WIDTH-1];
            r_mag     <= bus.binary_in[WIDTH-1] ? -bus.binary_in : bus.binary_in;
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          {r_scratch, r_mag} <= {w_adj, r_mag} << 1;
          r_cnt              <= r_cnt + 1'b1;
        end
        DONE: begin
          r_bcd  <= {r_sign, r_scratch};
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.codigo_BCD = r_bcd;

endmodule
